// File: rtl/if_pkg.sv
// Shared constants, entry type and elaboration helpers for the instruction-fetch stage.
package if_pkg;

    localparam int          INSN_BYTES = 4;
    localparam logic [31:0] NOP_INS    = 32'h0000_0000;

    // Queue entry at the default 32-bit widths; the fetch top builds the same layout at its own widths.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } fetch_entry_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO with flush. While full it still accepts a push in a cycle that also pops.
module if_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [clog2(DEPTH):0]  count
);

    localparam int               PTR_W     = clog2(DEPTH);
    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_CNT);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: fetch PC, 1-cycle instruction-memory interface and a prefetch queue
// flushed by redirects. Defining IF_PERF_CNT_EN adds the perf_fetched / perf_stall counters.
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter int                DATA_W       = 32,
    parameter int                DEPTH        = 4,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              im_req,
    output logic [ADDR_W-1:0] im_addr,
    input  logic [DATA_W-1:0] im_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_ins,
    output logic [ADDR_W-1:0] out_pc,
    output logic [ADDR_W-1:0] out_nextpc
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall
`endif
);

    localparam int                CNT_W      = clog2(DEPTH) + 1;
    localparam logic [CNT_W:0]    DEPTH_OCC  = (CNT_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INSN_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(INSN_BYTES - 1);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] ins;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              inflight_q, inflight_d;

    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [ADDR_W+DATA_W-1:0] fifo_rdata;
    entry_t            push_entry;
    entry_t            head_entry;
    logic              push;
    logic              pop;
    logic              issue;
    logic [CNT_W:0]    occ;

    assign out_valid = !fifo_empty;
    assign pop       = !fifo_empty && out_ready;
    // A response landing in a redirect cycle belongs to the abandoned path.
    assign push      = inflight_q && !redirect_valid;

    always_comb begin
        occ = {1'b0, fifo_count} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);
        // A saturated queue only admits a request when the head leaves and nothing is in flight.
        issue = !RST && !redirect_valid &&
                (fifo_full ? (pop && !inflight_q) : (occ < DEPTH_OCC));

        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = 1'b0;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ALIGN_MASK;
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + STEP;
            req_pc_d   = fetch_pc_q;
            inflight_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fetch_pc_q <= RESET_VECTOR;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
        end
    end

    assign im_req  = issue;
    assign im_addr = fetch_pc_q;

    assign push_entry = '{pc: req_pc_q, ins: im_rdata};
    assign head_entry = entry_t'(fifo_rdata);

    assign out_ins    = fifo_empty ? DATA_W'(NOP_INS) : head_entry.ins;
    assign out_pc     = head_entry.pc;
    assign out_nextpc = head_entry.pc + STEP;

    if_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (push_entry),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Counters survive redirects; only reset clears them.
    always_comb begin
        perf_fetched_d = perf_fetched_q + 32'(pop);
        perf_stall_d   = perf_stall_q + 32'(out_valid && !out_ready);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed self-checking bench for if_fetch_queue; a second instance covers PC wrap-around.
module tb_if_fetch_queue;

    logic        CLK;
    logic        RST;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        im_req;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ins;
    logic [31:0] out_pc;
    logic [31:0] out_nextpc;

    logic        RST_W;
    logic        im_req_w;
    logic [31:0] im_addr_w;
    logic [31:0] im_rdata_w;
    logic        out_valid_w;
    logic        out_ready_w;
    logic [31:0] out_ins_w;
    logic [31:0] out_pc_w;
    logic [31:0] out_nextpc_w;
    logic        redirect_valid_w;
    logic [31:0] redirect_pc_w;

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_stall;
    logic [31:0] perf_fetched_w, perf_stall_w;
`endif

    int total = 0;
    int bad   = 0;

    if_fetch_queue #(.RESET_VECTOR(32'h0000_0000)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .im_req         (im_req),
        .im_addr        (im_addr),
        .im_rdata       (im_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_ins        (out_ins),
        .out_pc         (out_pc),
        .out_nextpc     (out_nextpc)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    if_fetch_queue #(.RESET_VECTOR(32'hFFFF_FFF8)) dut_w (
        .CLK            (CLK),
        .RST            (RST_W),
        .redirect_valid (redirect_valid_w),
        .redirect_pc    (redirect_pc_w),
        .im_req         (im_req_w),
        .im_addr        (im_addr_w),
        .im_rdata       (im_rdata_w),
        .out_valid      (out_valid_w),
        .out_ready      (out_ready_w),
        .out_ins        (out_ins_w),
        .out_pc         (out_pc_w),
        .out_nextpc     (out_nextpc_w)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched_w),
        .perf_stall     (perf_stall_w)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Instruction memory: each word holds its own address, returned one cycle after the request.
    always @(posedge CLK) begin
        im_rdata   <= im_addr;
        im_rdata_w <= im_addr_w;
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic hold_reset();
        RST            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (2) @(posedge CLK);
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        hold_reset();
        out_ready = 1'b1;
        @(negedge CLK);
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        total++;
        if (im_req !== 1'b0) begin
            bad++; $display("FAIL reset_im_req: got %b want 0", im_req);
        end
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            if (i == 0) RST = 1'b0;
            @(negedge CLK);
            if (i == 0) begin
                total++;
                if (im_req !== 1'b1 || im_addr !== 32'h0) begin
                    bad++; $display("FAIL start_req: got req=%b addr=%h want req=1 addr=0", im_req, im_addr);
                end
            end
            if (i < 2) begin
                total++;
                if (out_valid !== 1'b0) begin
                    bad++; $display("FAIL start_latency c%0d: got valid=%b want 0", i, out_valid);
                end
            end else begin
                exp = 32'((i - 2) * 4);
                total++;
                if (out_valid !== 1'b1 || out_pc !== exp) begin
                    bad++; $display("FAIL start_pc c%0d: got valid=%b pc=%h want valid=1 pc=%h", i, out_valid, out_pc, exp);
                end
                total++;
                if (out_ins !== exp || out_nextpc !== exp + 32'd4) begin
                    bad++; $display("FAIL start_ins c%0d: got ins=%h next=%h want ins=%h next=%h", i, out_ins, out_nextpc, exp, exp + 32'd4);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp;
        hold_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            next_cycle();
            if (i == 0) RST = 1'b0;
            out_ready = (i >= 10);
            @(negedge CLK);
            if (i < 10) begin
                total++;
                if (im_req !== (i < 4)) begin
                    bad++; $display("FAIL bp_im_req c%0d: got %b want %b", i, im_req, (i < 4));
                end
                total++;
                if (out_valid !== (i >= 2)) begin
                    bad++; $display("FAIL bp_valid c%0d: got %b want %b", i, out_valid, (i >= 2));
                end
                if (i >= 2) begin
                    total++;
                    if (out_pc !== 32'h0) begin
                        bad++; $display("FAIL bp_head c%0d: got pc=%h want 0", i, out_pc);
                    end
                end
            end else begin
                exp = 32'((i - 10) * 4);
                total++;
                if (out_valid !== 1'b1 || out_pc !== exp || out_ins !== exp) begin
                    bad++; $display("FAIL bp_drain c%0d: got valid=%b pc=%h ins=%h want pc=%h", i, out_valid, out_pc, out_ins, exp);
                end
            end
        end
    endtask

    task automatic test_redirect();
        hold_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            next_cycle();
            if (i == 0) RST = 1'b0;
            redirect_valid = (i == 6);
            redirect_pc    = (i == 6) ? 32'h0000_0103 : 32'h0;
            @(negedge CLK);
            case (i)
                5: begin
                    total++;
                    if (out_valid !== 1'b1 || out_pc !== 32'hC) begin
                        bad++; $display("FAIL redir_pre: got valid=%b pc=%h want pc=0000000c", out_valid, out_pc);
                    end
                end
                6: begin
                    total++;
                    if (im_req !== 1'b0) begin
                        bad++; $display("FAIL redir_no_req: got %b want 0", im_req);
                    end
                end
                7: begin
                    total++;
                    if (im_req !== 1'b1 || im_addr !== 32'h100) begin
                        bad++; $display("FAIL redir_target_req: got req=%b addr=%h want req=1 addr=00000100", im_req, im_addr);
                    end
                    total++;
                    if (out_valid !== 1'b0) begin
                        bad++; $display("FAIL redir_flush c7: got valid=%b pc=%h want 0", out_valid, out_pc);
                    end
                end
                8: begin
                    total++;
                    if (out_valid !== 1'b0) begin
                        bad++; $display("FAIL redir_flush c8: got valid=%b pc=%h want 0", out_valid, out_pc);
                    end
                end
                9, 10: begin
                    total++;
                    if (out_valid !== 1'b1 || out_pc !== 32'h100 + 32'((i - 9) * 4)) begin
                        bad++; $display("FAIL redir_stream c%0d: got valid=%b pc=%h want pc=%h", i, out_valid, out_pc, 32'h100 + 32'((i - 9) * 4));
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic test_redirect_race();
        hold_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            next_cycle();
            if (i == 0) RST = 1'b0;
            redirect_valid = (i == 1) || (i == 2);
            redirect_pc    = (i == 1) ? 32'h200 : ((i == 2) ? 32'h300 : 32'h0);
            @(negedge CLK);
            if (i == 1 || i == 2) begin
                total++;
                if (im_req !== 1'b0) begin
                    bad++; $display("FAIL race_no_req c%0d: got %b want 0", i, im_req);
                end
            end
            if (i >= 2 && i <= 4) begin
                total++;
                if (out_valid !== 1'b0) begin
                    bad++; $display("FAIL race_discard c%0d: got valid=%b pc=%h want 0", i, out_valid, out_pc);
                end
            end
            if (i == 3) begin
                total++;
                if (im_req !== 1'b1 || im_addr !== 32'h300) begin
                    bad++; $display("FAIL race_last_wins: got req=%b addr=%h want req=1 addr=00000300", im_req, im_addr);
                end
            end
            if (i >= 5) begin
                total++;
                if (out_valid !== 1'b1 || out_pc !== 32'h300 + 32'((i - 5) * 4)) begin
                    bad++; $display("FAIL race_stream c%0d: got valid=%b pc=%h want pc=%h", i, out_valid, out_pc, 32'h300 + 32'((i - 5) * 4));
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            if (i == 0) RST_W = 1'b0;
            @(negedge CLK);
            if (i >= 2) begin
                exp = 32'hFFFF_FFF8 + 32'((i - 2) * 4);
                total++;
                if (out_valid_w !== 1'b1 || out_pc_w !== exp || out_nextpc_w !== exp + 32'd4) begin
                    bad++; $display("FAIL wrap_pc c%0d: got valid=%b pc=%h next=%h want pc=%h next=%h", i, out_valid_w, out_pc_w, out_nextpc_w, exp, exp + 32'd4);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        hold_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            if (i == 0) RST = 1'b0;
            @(negedge CLK);
        end
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h8) begin
            bad++; $display("FAIL async_pre: got valid=%b pc=%h want pc=00000008", out_valid, out_pc);
        end
        #2;
        RST = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || im_req !== 1'b0) begin
            bad++; $display("FAIL async_assert: got valid=%b req=%b want 0 0", out_valid, im_req);
        end
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            if (i == 0) RST = 1'b0;
            @(negedge CLK);
            if (i == 0) begin
                total++;
                if (im_req !== 1'b1 || im_addr !== 32'h0) begin
                    bad++; $display("FAIL async_restart_req: got req=%b addr=%h want req=1 addr=0", im_req, im_addr);
                end
            end
            if (i == 1) begin
                total++;
                if (out_valid !== 1'b0) begin
                    bad++; $display("FAIL async_restart_latency: got %b want 0", out_valid);
                end
            end
            if (i >= 2) begin
                total++;
                if (out_valid !== 1'b1 || out_pc !== 32'((i - 2) * 4)) begin
                    bad++; $display("FAIL async_restart_pc c%0d: got valid=%b pc=%h want pc=%h", i, out_valid, out_pc, 32'((i - 2) * 4));
                end
            end
        end
    endtask

`ifdef IF_PERF_CNT_EN
    task automatic test_perf();
        hold_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            next_cycle();
            if (i == 0) RST = 1'b0;
            out_ready      = (i >= 7) && (i < 15);
            redirect_valid = (i == 15);
            redirect_pc    = (i == 15) ? 32'h400 : 32'h0;
            @(negedge CLK);
            if (i == 0) begin
                total++;
                if (perf_fetched !== 32'd0 || perf_stall !== 32'd0) begin
                    bad++; $display("FAIL perf_reset: got fetched=%0d stall=%0d want 0 0", perf_fetched, perf_stall);
                end
            end
            if (i == 15) begin
                total++;
                if (perf_fetched !== 32'd8 || perf_stall !== 32'd5) begin
                    bad++; $display("FAIL perf_count: got fetched=%0d stall=%0d want 8 5", perf_fetched, perf_stall);
                end
            end
            if (i == 17) begin
                total++;
                if (perf_fetched !== 32'd8 || perf_stall !== 32'd6) begin
                    bad++; $display("FAIL perf_after_redirect: got fetched=%0d stall=%0d want 8 6", perf_fetched, perf_stall);
                end
            end
        end
        redirect_valid = 1'b0;
    endtask
`endif

    initial begin
        RST              = 1'b1;
        RST_W            = 1'b1;
        redirect_valid   = 1'b0;
        redirect_pc      = 32'h0;
        out_ready        = 1'b0;
        out_ready_w      = 1'b1;
        redirect_valid_w = 1'b0;
        redirect_pc_w    = 32'h0;

        test_reset();
        test_backpressure();
        test_redirect();
        test_redirect_race();
        test_wrap();
        test_async_reset();
`ifdef IF_PERF_CNT_EN
        test_perf();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Parametrised instruction-fetch stage for the MIPS pipeline; successor to the single-register PC fetch.
- Keeps the fetch PC, issues one request per cycle to a synchronous instruction memory with 1-cycle read latency, and buffers returned instructions with their PCs in a prefetch queue.
- Presents instructions to decode over a valid/ready handshake and accepts branch/jump redirects that flush all speculative state.

Parameters:
- ADDR_W, 32, PC / memory address width.
- DATA_W, 32, instruction width.
- DEPTH, 4, prefetch queue entries; power of two, >= 2.
- RESET_VECTOR, 0, PC fetched first after reset.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  reset, asynchronous, active-high.
- redirect_valid  in  1  redirect request from EX (branch/jump taken).
- redirect_pc  in  ADDR_W  redirect target; bits [1:0] ignored and forced to 0.
- im_req  out  1  instruction-memory read strobe.
- im_addr  out  ADDR_W  read address, word aligned.
- im_rdata  in  DATA_W  read data, valid exactly one cycle after an im_req cycle.
- out_valid  out  1  queue head holds a valid instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_ins  out  DATA_W  head instruction.
- out_pc  out  ADDR_W  PC of the head instruction.
- out_nextpc  out  ADDR_W  out_pc + 4, wraps modulo 2^ADDR_W.

Behaviour:
- **Reset** (async, any cycle, including mid-flush): fetch_pc = RESET_VECTOR; queue empty; in-flight flag = 0; out_valid = 0; im_req = 0 while RST is high.
- **Queue outputs:** out_ins, out_pc and out_nextpc are the head entry's fields; their value is don't-care when out_valid = 0.
- **Issue rule:**
  - im_req = !RST && !redirect_valid && (count + inflight - pop < DEPTH), where pop = out_valid && out_ready.
  - im_addr = fetch_pc.
  - On issue: fetch_pc += 4 (wraps) and inflight <= 1; otherwise inflight <= 0.
- **Response:** in the cycle after an issue, {im_addr_prev, im_rdata} is pushed at the tail, unless that cycle carries a redirect (see Redirect).
- **Latency:**
  - Request in cycle N, push at the end of N+1, out_valid in N+2.
  - First out_valid is in the 3rd cycle after RST deassert, with out_pc = RESET_VECTOR.
- **Throughput:** with out_ready held high, one instruction per cycle sustained.
- **Handshake:**
  - Transfer occurs when out_valid && out_ready.
  - The head stays stable while out_valid && !out_ready.
  - out_valid never drops without a transfer, except on redirect or reset.
- **Simultaneous push and pop:** both take effect; count is unchanged.
  - A full queue with a pop accepts a push in the same cycle.
  - Overflow is impossible by the issue rule.
  - Pop on an empty queue is ignored.
- **Redirect** (redirect_valid = 1 in cycle R):
  - The queue is cleared at the end of R.
  - Any response arriving in R is discarded.
  - No request is issued in R.
  - fetch_pc <= redirect_pc.
  - A handshake occurring in R still counts as a transfer.
  - Request to redirect_pc in R+1; out_valid with out_pc = redirect_pc in R+3.
- **Back-to-back redirects:** the last one wins; each restarts the R+1/R+3 timing.
- **Address/counter widths:**
  - Queue pointers are log2(DEPTH) bits and wrap naturally.
  - count is log2(DEPTH)+1 bits, range 0..DEPTH.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- **Defined:** add outputs perf_fetched (32 bit) and perf_stall (32 bit), both reset to 0.
  - perf_fetched increments on every transfer.
  - perf_stall increments each cycle with out_valid && !out_ready.
  - Both wrap at 2^32 and are not cleared by redirect.
- **Undefined:** the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package if_pkg holds:
  - INSN_BYTES = 4.
  - NOP_INS = 32'h0000_0000.
  - A struct/typedef for a queue entry {pc, ins}.
  - The log2 helper function.
- One natural sub-module: if_fifo.
  - Synchronous FIFO with parameters DEPTH and WIDTH.
  - Ports: push, pop, flush, full, empty, count.
  - Instantiated once with WIDTH = ADDR_W + DATA_W.

Test Plan:
1. **Reset start:** release RST, memory returns word = address, out_ready = 1.
   - out_valid first high 3 cycles after release.
   - out_pc sequence 0, 4, 8, 12 on consecutive cycles.
   - out_nextpc = out_pc + 4.
2. **Backpressure, DEPTH = 4:** hold out_ready = 0 for 10 cycles.
   - im_req drops after 4 queued entries plus no in-flight.
   - Head stays at pc 0.
   - Release: pcs 0..28 delivered in order with no gaps or duplicates.
3. **Redirect mid-stream:** redirect_valid one cycle with redirect_pc = 0x0000_0103.
   - No im_req that cycle.
   - im_addr = 0x100 next cycle.
   - Next delivered out_pc = 0x100, 2 cycles later; no stale PCs delivered.
4. **Redirect racing a response, plus back-to-back redirects:**
   - Redirect in the cycle a response returns: the response is discarded.
   - Redirects to 0x200 then 0x300 on consecutive cycles: only 0x300 stream appears.
5. **Wrap and async reset:**
   - RESET_VECTOR = 0xFFFF_FFF8: out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
   - Assert RST mid-stream between clock edges: out_valid falls immediately and restart matches scenario 1.
6. **With IF_PERF_CNT_EN:** 8 transfers and 5 stall cycles give perf_fetched = 8 and perf_stall = 5; a redirect does not clear either counter.
